// File: rtl/ct_byte_sink_if.sv
// Byte-sink bus: upstream word-pair offer plus the downstream valid/ready byte stream.
// master = producer/consumer environment, slave = the sink itself.
interface ct_byte_sink_if;
    logic        readin;
    logic [15:0] din1;
    logic [15:0] din2;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output readin, din1, din2, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  readin, din1, din2, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/ct_byte_sink.sv
// Register FIFO of 32-bit word pairs, serialised as little-endian bytes on a valid/ready stream.
// Also counts delivered bytes toward a polynomial length and flags dropped pairs.
module ct_byte_sink #(
    parameter int DEPTH       = 8,
    parameter int TOTAL_BYTES = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set,
    input  logic                   clear,
    ct_byte_sink_if.slave          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   done,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TOTAL_BYTES + 1);

    logic [31:0]   entry_q [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [1:0]    bi_reg;
    logic [LW-1:0] level_reg;
    logic [CW-1:0] count_reg;
    logic          done_reg;
    logic          overflow_reg;

    logic        valid;
    logic        xfer;
    logic        free;
    logic        offer;
    logic        wr_ok;
    logic [31:0] head;

    // clear wins over both the write and the transfer on the same edge
    always_comb begin
        head  = entry_q[rd_ptr_reg];
        valid = (level_reg != '0);
        xfer  = set && !clear && valid && bus.dout_ready;
        free  = xfer && (bi_reg == 2'd3);
        offer = set && !clear && bus.readin;
        wr_ok = offer && ((level_reg < LW'(DEPTH)) || free);
    end

    assign bus.dout_valid = valid;
    assign bus.dout       = valid ? head[{bi_reg, 3'b000} +: 8] : 8'h00;
    assign level          = level_reg;
    assign done           = done_reg;
    assign overflow       = overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] entry_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (wr_ok && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= {bus.din2, bus.din1};
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            bi_reg       <= '0;
            level_reg    <= '0;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (set) begin
            if (clear) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                bi_reg       <= '0;
                level_reg    <= '0;
                count_reg    <= '0;
                done_reg     <= 1'b0;
                overflow_reg <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (offer && !wr_ok) begin
                    overflow_reg <= 1'b1;
                end
                if (xfer) begin
                    bi_reg <= bi_reg + 1'b1;
                end
                if (free) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                // a write landing on the same edge as a free leaves occupancy unchanged
                if (wr_ok && !free) begin
                    level_reg <= level_reg + 1'b1;
                end else if (free && !wr_ok) begin
                    level_reg <= level_reg - 1'b1;
                end
                if (xfer && (count_reg != CW'(TOTAL_BYTES))) begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(TOTAL_BYTES - 1)) begin
                        done_reg <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ct_byte_sink.sv
// Self-checking bench for ct_byte_sink: per-cycle vector table, hand sequences for the
// multi-cycle corners, and a byte scoreboard checked on every transfer.
module tb_ct_byte_sink;
    localparam int DEPTH = 8;
    localparam int TOTAL = 128;

    logic       clk;
    logic       reset;
    logic       set;
    logic       clear;
    logic [3:0] level;
    logic       done;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q [$];

    ct_byte_sink_if bus ();

    ct_byte_sink #(.DEPTH(DEPTH), .TOTAL_BYTES(TOTAL)) dut (
        .clk      (clk),
        .reset    (reset),
        .set      (set),
        .clear    (clear),
        .bus      (bus),
        .level    (level),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic        rd;
        logic        clr;
        logic        rdy;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  el;
        logic        eo;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] d1, input logic [15:0] d2);
        exp_q.push_back(d1[7:0]);
        exp_q.push_back(d1[15:8]);
        exp_q.push_back(d2[7:0]);
        exp_q.push_back(d2[15:8]);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.readin     = 1'b0;
        bus.dout_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_level", {28'd0, level}, 0);
        chk("drain_valid", {31'd0, bus.dout_valid}, 0);
    endtask

    task automatic do_clear();
        set        = 1'b1;
        clear      = 1'b1;
        bus.readin = 1'b1;
        bus.din1   = 16'hDEAD;
        bus.din2   = 16'hBEEF;
        cycle();
        clear      = 1'b0;
        bus.readin = 1'b0;
        exp_q.delete();
        xfer_cnt = 0;
    endtask

    // Byte scoreboard: evaluated mid-cycle, i.e. on exactly the inputs the next edge will see.
    always @(negedge clk) begin
        if (reset && set && !clear && bus.dout_valid && bus.dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL byte_unexpected got=%h want=none", bus.dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    failures++;
                    $display("FAIL byte_stream got=%h want=%h", bus.dout, e);
                end else begin
                    $display("ok   byte %h", bus.dout);
                end
            end
            xfer_cnt++;
        end
    end

    initial begin
        // reset with arbitrary inputs, checked before the first edge
        reset          = 1'b0;
        set            = 1'b1;
        clear          = 1'b0;
        bus.readin     = 1'b1;
        bus.din1       = 16'h5A5A;
        bus.din2       = 16'hA5A5;
        bus.dout_ready = 1'b1;
        #2;
        chk("rst_dout", {24'd0, bus.dout}, 0);
        chk("rst_valid", {31'd0, bus.dout_valid}, 0);
        chk("rst_level", {28'd0, level}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        cycle();
        chk("rst_hold_level", {28'd0, level}, 0);
        reset      = 1'b1;
        bus.readin = 1'b0;

        // single pair then set-gating, one row per clock edge
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA1B2, 16'hC3D4, 1'b1, 8'hB2, 4'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'hA1, 4'd1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'hD4, 4'd1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'hC3, 4'd1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 1'b1, 8'h34, 4'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 8'h34, 4'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 8'h34, 4'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 8'h34, 4'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'h12, 4'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'h78, 4'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'h56, 4'd1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            set            = tbl[i].s;
            bus.readin     = tbl[i].rd;
            clear          = tbl[i].clr;
            bus.dout_ready = tbl[i].rdy;
            bus.din1       = tbl[i].d1;
            bus.din2       = tbl[i].d2;
            if (tbl[i].s && tbl[i].rd && !tbl[i].clr) push_pair(tbl[i].d1, tbl[i].d2);
            cycle();
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.dout_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_dout", i), {24'd0, bus.dout}, {24'd0, tbl[i].ed});
            chk($sformatf("vec%0d_level", i), {28'd0, level}, {28'd0, tbl[i].el});
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].eo});
        end
        set = 1'b1;
        chk("vec_sb_empty", exp_q.size(), 0);

        // backpressure: nine pairs into an 8-deep FIFO, the ninth is dropped
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.readin = 1'b1;
            bus.din1   = {4'h0, 4'(k), 8'h00};
            bus.din2   = {4'h0, 4'(k), 8'h01};
            if (k < DEPTH) push_pair(bus.din1, bus.din2);
            cycle();
        end
        bus.readin = 1'b0;
        chk("ovf_level", {28'd0, level}, 8);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_head_dout", {24'd0, bus.dout}, 8'h00);
        drain(64);
        chk("ovf_sticky", {31'd0, overflow}, 1);
        do_clear();
        chk("clr_overflow", {31'd0, overflow}, 0);
        chk("clr_level", {28'd0, level}, 0);

        // full FIFO with a simultaneous free at bi=3
        bus.dout_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.readin = 1'b1;
            bus.din1   = {4'h1, 4'(k), 8'h10};
            bus.din2   = {4'h2, 4'(k), 8'h20};
            push_pair(bus.din1, bus.din2);
            cycle();
        end
        bus.readin     = 1'b0;
        bus.dout_ready = 1'b1;
        chk("full_level", {28'd0, level}, 8);
        for (int j = 0; j < 3; j++) cycle();
        bus.readin = 1'b1;
        bus.din1   = 16'hBEEF;
        bus.din2   = 16'hCAFE;
        push_pair(16'hBEEF, 16'hCAFE);
        cycle();
        bus.readin = 1'b0;
        chk("full_free_level", {28'd0, level}, 8);
        chk("full_free_ovf", {31'd0, overflow}, 0);
        drain(64);

        // completion: 32 pairs at one per 4 cycles
        do_clear();
        bus.dout_ready = 1'b1;
        for (int p = 0; p < 32; p++) begin
            for (int j = 0; j < 4; j++) begin
                bus.readin = (j == 0);
                bus.din1   = {8'(p), 8'(p + 1)};
                bus.din2   = {8'(p ^ 8'h5A), 8'(p + 3)};
                if (j == 0) push_pair(bus.din1, bus.din2);
                cycle();
                chk("done_track", {31'd0, done}, {31'd0, (xfer_cnt >= TOTAL)});
            end
        end
        bus.readin = 1'b0;
        for (int j = 0; j < 8 && exp_q.size() != 0; j++) begin
            cycle();
            chk("done_track", {31'd0, done}, {31'd0, (xfer_cnt >= TOTAL)});
        end
        chk("done_final", {31'd0, done}, 1);
        chk("done_bytes", xfer_cnt, TOTAL);
        chk("done_sb_empty", exp_q.size(), 0);
        do_clear();
        chk("clr_done", {31'd0, done}, 0);
        chk("clr_level2", {28'd0, level}, 0);

        // asynchronous reset after 10 bytes of a new stream
        begin
            int n;
            n = 0;
            while (xfer_cnt < 10 && n < 64) begin
                bus.readin = ((n % 4) == 0);
                bus.din1   = 16'h7700 + 16'(n);
                bus.din2   = 16'h8800 + 16'(n);
                if (bus.readin) push_pair(bus.din1, bus.din2);
                cycle();
                n++;
            end
            chk("rst_mid_bytes", xfer_cnt, 10);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.dout_valid}, 0);
        chk("rst_mid_level", {28'd0, level}, 0);
        chk("rst_mid_dout", {24'd0, bus.dout}, 0);
        exp_q.delete();
        cycle();
        reset      = 1'b1;
        bus.readin = 1'b1;
        bus.din1   = 16'h0F1E;
        bus.din2   = 16'h2D3C;
        push_pair(16'h0F1E, 16'h2D3C);
        cycle();
        chk("post_rst_dout", {24'd0, bus.dout}, 8'h1E);
        drain(16);
        chk("post_rst_done", {31'd0, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ct_byte_sink.md
# ct_byte_sink

Downstream stage of the compress/encode datapath. It captures each packed 16-bit word pair emitted on the encoder's `readout_ok` pulse into a small register FIFO, then serialises the pairs as little-endian bytes on a valid/ready byte stream toward the ciphertext output bus. It counts bytes against the expected polynomial length and reports completion and data loss. Upstream has no backpressure, so this block is the sole rate-matching point between the encoder pipeline and the bus.

## Interface

Parameters:
- `DEPTH`, 8: FIFO capacity in word pairs (4 bytes each); power of two, ≥2.
- `TOTAL_BYTES`, 128: bytes per polynomial (128 for DD=4, 320 for DD=10).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (`reset`=0 clears all state immediately).
- `set`  in  1  global advance enable; when 0, all state holds and no write or transfer occurs.
- `clear`  in  1  synchronous, qualified by `set`; empties the FIFO and clears the byte count, `done` and `overflow`.
- `readin`  in  1  upstream `readout_ok`; one word pair is offered per cycle while high.
- `din1`  in  16  first packed word (earlier coefficients).
- `din2`  in  16  second packed word.
- `dout`  out  8  current output byte.
- `dout_valid`  out  1  `dout` holds a valid byte.
- `dout_ready`  in  1  consumer accepts the byte.
- `level`  out  $clog2(DEPTH)+1  number of occupied entries.
- `done`  out  1  sticky; `TOTAL_BYTES` bytes have been transferred.
- `overflow`  out  1  sticky; a word pair was dropped.

## Operation

- Storage: `DEPTH` entries × 32 bits, held in registers with no RAM block. Entry = {`din2`,`din1`}. Write pointer, read pointer and a 2-bit byte index `bi`.
- Write: at an edge with `set`=1, `readin`=1 and `clear`=0, the pair is written at the write pointer, which then increments and wraps modulo `DEPTH`.
- Byte order within an entry: `din1[7:0]`, `din1[15:8]`, `din2[7:0]`, `din2[15:8]` (bi = 0..3).
- Output: `dout_valid` = (`level` != 0). `dout` = byte `bi` of the head entry, and 8'h00 when empty. Both are driven from registers through the mux only.
- Transfer: occurs at an edge with `set`=1, `dout_valid`=1 and `dout_ready`=1. On a transfer, `bi` increments. When `bi`=3 transfers, the head is freed: the read pointer wraps and increments, `bi` returns to 0, and `level` decrements.
- Occupancy: the head entry counts in `level` until its 4th byte transfers.
- Full rule: a write is accepted if `level` < `DEPTH`, or if the head's `bi`=3 byte transfers on the same edge. Otherwise the pair is dropped, `overflow` is set, and `level` is unchanged.
- Simultaneous write and free: `level` is unchanged and both pointers advance.
- Byte count: increments on each transfer and saturates at `TOTAL_BYTES`. `done` sets on the edge where the count reaches `TOTAL_BYTES`.
- After `done`: writes and transfers continue normally; `done` stays high.
- `clear`: takes priority over a write and a transfer on the same edge. The offered pair is discarded and not flagged as overflow.

## Timing

- Reset values: `dout`=0, `dout_valid`=0, `level`=0, `done`=0, `overflow`=0; pointers and `bi` = 0.
- Latency: a pair written at edge E makes `dout_valid`=1 with byte 0 after E, provided the FIFO was empty. First transfer at E+1.
- Throughput: one byte per cycle with no bubble between entries. Sustained input must average ≤1 pair per 4 cycles.
- Flow control: `dout_valid` and `dout` hold stable while `dout_ready`=0. `dout_valid` never drops without a transfer, except on `reset`, on `clear`, or when the last byte transfers.
- `set`=0: the cycle is a no-op even if `readin`, `dout_valid` and `dout_ready` are all 1. Outputs hold.
- `reset` asserted mid-stream: all state clears asynchronously and FIFO contents are lost. The first edge after release with `set`=1 operates normally.

## Test plan

- Reset: drive `reset`=0 with arbitrary inputs → `dout`=0, `dout_valid`=0, `level`=0, `done`=0, `overflow`=0 before any clock edge.
- Single pair: `din1`=16'hA1B2, `din2`=16'hC3D4, `dout_ready`=1 → bytes B2, A1, D4, C3 on 4 consecutive edges; `dout_valid` low after the 4th; `level` goes 1→0.
- Backpressure and overflow: `dout_ready`=0, write 9 pairs 16'h0k00/16'h0k01 (k=0..8) → `level`=8, `overflow`=1, pair 8 absent. Raise ready → 32 bytes for pairs 0..7 in order.
- Full with simultaneous free: `level`=8 and head at bi=3 with ready=1, write 16'hBEEF/16'hCAFE on the same edge → `overflow` stays 0, `level` stays 8, and the new pair drains last.
- `set` gating: `set`=0 for 3 cycles with `readin`=1 and `dout_ready`=1 → `level`, `dout` and the byte count are unchanged; normal operation resumes when `set`=1.
- Completion, clear and reset: `TOTAL_BYTES`=128, 32 pairs fed 1 per 4 cycles → `done` rises on the edge of the 128th transfer. Then `clear` → `done`=0, `level`=0. Reset asserted after 10 bytes of a new stream → immediate clear.
